// File: rtl/alu_issue_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_if
// Description : Decode-side, hazard/forwarding and ALU-side signals of the
//               ID/EX issue stage.
// Revision    : 1.0
// ============================================================================
interface alu_issue_if #(
  parameter int DW = 64,
  parameter int RW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [10:0]   in_opcode;
  logic [RW-1:0] in_rn_idx;
  logic [RW-1:0] in_rm_idx;
  logic [RW-1:0] in_rd_idx;
  logic [DW-1:0] in_rn_data;
  logic [DW-1:0] in_rm_data;
  logic [DW-1:0] in_imm;
  logic [5:0]    in_shamt;
  logic          stall;
  logic          flush;
  logic          exm_wr_en;
  logic [RW-1:0] exm_rd_idx;
  logic [DW-1:0] exm_data;
  logic          mwb_wr_en;
  logic [RW-1:0] mwb_rd_idx;
  logic [DW-1:0] mwb_data;
  logic          out_valid;
  logic [DW-1:0] alu_r1;
  logic [DW-1:0] alu_r2;
  logic [3:0]    alu_tag;
  logic [RW-1:0] out_rd_idx;
  logic          illegal;

  modport master (
    output in_valid, in_opcode, in_rn_idx, in_rm_idx, in_rd_idx,
           in_rn_data, in_rm_data, in_imm, in_shamt, stall, flush,
           exm_wr_en, exm_rd_idx, exm_data, mwb_wr_en, mwb_rd_idx, mwb_data,
    input  in_ready, out_valid, alu_r1, alu_r2, alu_tag, out_rd_idx, illegal
  );

  modport slave (
    input  in_valid, in_opcode, in_rn_idx, in_rm_idx, in_rd_idx,
           in_rn_data, in_rm_data, in_imm, in_shamt, stall, flush,
           exm_wr_en, exm_rd_idx, exm_data, mwb_wr_en, mwb_rd_idx, mwb_data,
    output in_ready, out_valid, alu_r1, alu_r2, alu_tag, out_rd_idx, illegal
  );
endinterface
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_stage
// Description : ID/EX issue register for the 64-bit ALU: LEGv8 opcode decode,
//               operand-2 select, valid/stall/flush and EX/MEM, MEM/WB forwarding.
// Revision    : 1.0
// ============================================================================
module alu_issue_stage #(
  parameter int DW = 64,
  parameter int RW = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_issue_if.slave bus
);

  localparam logic [RW-1:0] c_XZR     = {RW{1'b1}};
  localparam logic [3:0]    c_TAG_NOP = 4'b0111;

  logic          w_accept;
  logic [3:0]    w_tag;
  logic          w_op2_fwd;
  logic [DW-1:0] w_op2_data;
  logic [RW-1:0] w_rd_idx;
  logic          w_illegal;

  logic          r_valid;
  logic [3:0]    r_tag;
  logic [RW-1:0] r_rn_idx;
  logic [RW-1:0] r_rm_idx;
  logic [RW-1:0] r_rd_idx;
  logic [DW-1:0] r_rn_data;
  logic [DW-1:0] r_op2_data;
  logic          r_op2_fwd;
  logic          r_illegal;

  assign bus.in_ready = ~bus.stall;
  assign w_accept     = bus.in_valid & ~bus.stall & ~bus.flush;

  always_comb begin
    w_tag      = c_TAG_NOP;
    w_op2_fwd  = 1'b1;
    w_op2_data = bus.in_rm_data;
    w_rd_idx   = bus.in_rd_idx;
    w_illegal  = 1'b0;
    casez (bus.in_opcode)
      11'b10001010000: w_tag = 4'b0000;
      11'b10101010000: w_tag = 4'b0001;
      11'b10001011000: w_tag = 4'b0010;
      11'b1001000100?,
      11'b11111000010,
      11'b11111000000: begin
        w_tag      = 4'b0010;
        w_op2_fwd  = 1'b0;
        w_op2_data = bus.in_imm;
      end
      11'b11010011011,
      11'b11010011010: begin
        w_tag      = bus.in_opcode[0] ? 4'b0011 : 4'b0100;
        w_op2_fwd  = 1'b0;
        w_op2_data = {{(DW-6){1'b0}}, bus.in_shamt};
      end
      11'b10110100???: w_tag = c_TAG_NOP;
      default: begin
        w_rd_idx  = c_XZR;
        w_illegal = 1'b1;
      end
    endcase
  end

  // Flush only kills valid; the remaining registers keep whatever they held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_tag      <= c_TAG_NOP;
      r_rn_idx   <= '0;
      r_rm_idx   <= '0;
      r_rd_idx   <= '0;
      r_rn_data  <= '0;
      r_op2_data <= '0;
      r_op2_fwd  <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (!bus.stall) begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_tag      <= w_tag;
        r_rn_idx   <= bus.in_rn_idx;
        r_rm_idx   <= bus.in_rm_idx;
        r_rd_idx   <= w_rd_idx;
        r_rn_data  <= bus.in_rn_data;
        r_op2_data <= w_op2_data;
        r_op2_fwd  <= w_op2_fwd;
      end
    end
    if (rst_n && w_accept && w_illegal) begin
      r_illegal <= 1'b1;
    end
  end

  function automatic logic [DW-1:0] f_fwd(
    input logic [RW-1:0] idx,
    input logic [DW-1:0] stored,
    input logic          exm_en,
    input logic [RW-1:0] exm_idx,
    input logic [DW-1:0] exm_val,
    input logic          mwb_en,
    input logic [RW-1:0] mwb_idx,
    input logic [DW-1:0] mwb_val
  );
    if (idx == c_XZR)                     return '0;
    else if (exm_en && (exm_idx == idx))  return exm_val;
    else if (mwb_en && (mwb_idx == idx))  return mwb_val;
    else                                  return stored;
  endfunction

  // Forwarding looks at the registered indices so a stalled instruction keeps
  // picking up results that retire while it waits.
  assign bus.alu_r1 = f_fwd(r_rn_idx, r_rn_data,
                            bus.exm_wr_en, bus.exm_rd_idx, bus.exm_data,
                            bus.mwb_wr_en, bus.mwb_rd_idx, bus.mwb_data);
  assign bus.alu_r2 = r_op2_fwd
                    ? f_fwd(r_rm_idx, r_op2_data,
                            bus.exm_wr_en, bus.exm_rd_idx, bus.exm_data,
                            bus.mwb_wr_en, bus.mwb_rd_idx, bus.mwb_data)
                    : r_op2_data;

  assign bus.out_valid  = r_valid;
  assign bus.alu_tag    = r_tag;
  assign bus.out_rd_idx = r_rd_idx;
  assign bus.illegal    = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_stage
// Description : Directed self-checking bench for alu_issue_stage.
// Revision    : 1.0
// ============================================================================
module tb_alu_issue_stage;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  alu_issue_if #(.DW(64), .RW(5)) ifc ();

  alu_issue_stage #(.DW(64), .RW(5)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [10:0] c_AND  = 11'b10001010000;
  localparam logic [10:0] c_ORR  = 11'b10101010000;
  localparam logic [10:0] c_ADD  = 11'b10001011000;
  localparam logic [10:0] c_ADDI = 11'b10010001000;
  localparam logic [10:0] c_LSL  = 11'b11010011011;
  localparam logic [10:0] c_BAD  = 11'h7FF;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [10:0] op, input logic [4:0] rn, input logic [4:0] rm,
                       input logic [4:0] rd, input logic [63:0] rnd, input logic [63:0] rmd,
                       input logic [63:0] imm, input logic [5:0] sh);
    ifc.in_valid   = 1'b1;
    ifc.in_opcode  = op;
    ifc.in_rn_idx  = rn;
    ifc.in_rm_idx  = rm;
    ifc.in_rd_idx  = rd;
    ifc.in_rn_data = rnd;
    ifc.in_rm_data = rmd;
    ifc.in_imm     = imm;
    ifc.in_shamt   = sh;
  endtask

  task automatic no_fwd();
    ifc.exm_wr_en  = 1'b0;
    ifc.exm_rd_idx = '0;
    ifc.exm_data   = '0;
    ifc.mwb_wr_en  = 1'b0;
    ifc.mwb_rd_idx = '0;
    ifc.mwb_data   = '0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    drive(c_AND, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0, 6'd0);
    ifc.in_valid = 1'b0;
    ifc.stall    = 1'b0;
    ifc.flush    = 1'b0;
    no_fwd();
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_valid",   64'(ifc.out_valid), 64'd0);
    check("rst_tag",     64'(ifc.alu_tag),   64'd7);
    check("rst_illegal", 64'(ifc.illegal),   64'd0);
    check("rst_ready",   64'(ifc.in_ready),  64'd1);

    // ADD X3,X1,X2
    drive(c_ADD, 5'd1, 5'd2, 5'd3, 64'd5, 64'd7, 64'd0, 6'd0);
    tick();
    check("add_valid", 64'(ifc.out_valid),  64'd1);
    check("add_tag",   64'(ifc.alu_tag),    64'd2);
    check("add_r1",    ifc.alu_r1,          64'd5);
    check("add_r2",    ifc.alu_r2,          64'd7);
    check("add_rd",    64'(ifc.out_rd_idx), 64'd3);

    // Forward priority on rn
    ifc.exm_wr_en = 1'b1; ifc.exm_rd_idx = 5'd1; ifc.exm_data = 64'd100;
    ifc.mwb_wr_en = 1'b1; ifc.mwb_rd_idx = 5'd1; ifc.mwb_data = 64'd200;
    #1;
    check("fwd_exm_r1", ifc.alu_r1, 64'd100);
    check("fwd_r2_untouched", ifc.alu_r2, 64'd7);
    ifc.exm_wr_en = 1'b0;
    #1;
    check("fwd_mwb_r1", ifc.alu_r1, 64'd200);
    ifc.mwb_rd_idx = 5'd2;
    #1;
    check("fwd_mwb_r2", ifc.alu_r2, 64'd200);
    no_fwd();

    // LSL X4,X1,#12 with a forward aimed at rm that must be ignored
    drive(c_LSL, 5'd1, 5'd2, 5'd4, 64'd5, 64'h999, 64'd0, 6'd12);
    ifc.exm_wr_en = 1'b1; ifc.exm_rd_idx = 5'd2; ifc.exm_data = 64'hABC;
    tick();
    check("lsl_tag", 64'(ifc.alu_tag), 64'd3);
    check("lsl_r2",  ifc.alu_r2,       64'd12);
    check("lsl_r1",  ifc.alu_r1,       64'd5);

    // ADDI X5,X31,#9 with a forward to X31 that must be ignored
    drive(c_ADDI, 5'd31, 5'd0, 5'd5, 64'h1234, 64'd0, 64'd9, 6'd0);
    ifc.exm_rd_idx = 5'd31; ifc.exm_data = 64'hFF;
    tick();
    check("addi_tag", 64'(ifc.alu_tag),    64'd2);
    check("addi_r1",  ifc.alu_r1,          64'd0);
    check("addi_r2",  ifc.alu_r2,          64'd9);
    check("addi_rd",  64'(ifc.out_rd_idx), 64'd5);
    no_fwd();

    // ADD X6,X7,X8 then stall for three cycles while ORR is offered
    drive(c_ADD, 5'd7, 5'd8, 5'd6, 64'h11, 64'h22, 64'd0, 6'd0);
    tick();
    check("pre_stall_r1", ifc.alu_r1, 64'h11);
    drive(c_ORR, 5'd10, 5'd11, 5'd9, 64'h33, 64'h44, 64'd0, 6'd0);
    ifc.stall = 1'b1;
    #1;
    check("stall_ready", 64'(ifc.in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", 64'(ifc.out_valid),  64'd1);
      check("stall_tag",   64'(ifc.alu_tag),    64'd2);
      check("stall_rd",    64'(ifc.out_rd_idx), 64'd6);
      check("stall_r2",    ifc.alu_r2,          64'h22);
      if (i == 1) begin
        ifc.mwb_wr_en = 1'b1; ifc.mwb_rd_idx = 5'd7; ifc.mwb_data = 64'h55;
        #1;
        check("stall_fwd_r1", ifc.alu_r1, 64'h55);
      end else begin
        check("stall_r1", ifc.alu_r1, (i == 0) ? 64'h11 : 64'h55);
      end
    end
    ifc.stall = 1'b0;
    no_fwd();
    tick();
    check("orr_tag", 64'(ifc.alu_tag),    64'd1);
    check("orr_rd",  64'(ifc.out_rd_idx), 64'd9);
    check("orr_r1",  ifc.alu_r1,          64'h33);

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(ifc.out_valid), 64'd0);
    check("arst_tag",   64'(ifc.alu_tag),   64'd7);
    check("arst_rd",    64'(ifc.out_rd_idx), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Flush beats stall; an illegal opcode under flush is not accepted
    drive(c_ADD, 5'd1, 5'd2, 5'd3, 64'd5, 64'd7, 64'd0, 6'd0);
    tick();
    check("reissue_valid", 64'(ifc.out_valid), 64'd1);
    drive(c_BAD, 5'd1, 5'd2, 5'd12, 64'd5, 64'd7, 64'd0, 6'd0);
    ifc.flush = 1'b1;
    ifc.stall = 1'b1;
    tick();
    check("flush_valid",   64'(ifc.out_valid), 64'd0);
    check("flush_illegal", 64'(ifc.illegal),   64'd0);
    ifc.flush = 1'b0;
    ifc.stall = 1'b0;

    // Illegal opcode accepted
    tick();
    check("bad_valid",   64'(ifc.out_valid),  64'd1);
    check("bad_tag",     64'(ifc.alu_tag),    64'd7);
    check("bad_rd",      64'(ifc.out_rd_idx), 64'd31);
    check("bad_illegal", 64'(ifc.illegal),    64'd1);
    drive(c_ADD, 5'd1, 5'd2, 5'd3, 64'd5, 64'd7, 64'd0, 6'd0);
    ifc.in_valid = 1'b0;
    tick();
    check("idle_valid",     64'(ifc.out_valid), 64'd0);
    check("sticky_illegal", 64'(ifc.illegal),   64'd1);
    ifc.in_valid = 1'b1;
    tick();
    check("legal_rd",        64'(ifc.out_rd_idx), 64'd3);
    check("sticky_illegal2", 64'(ifc.illegal),    64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
